// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Computes a WIDTH-bit add or subtract by reusing one 4-bit ripple-carry slice.
//   Each clock processes one nibble, least-significant first. The carry between
//   nibbles is held in a register. A start/busy/done handshake sequences each
//   operation.
// Ports
//   clk    : clock; all state changes on the rising edge
//   rst_n  : asynchronous, active-low reset
//   start  : operation request; accepted only in IDLE or DONE
//   op_sub : 0 = a + b + cin, 1 = a - b (cin ignored)
//   a, b   : operands, captured on an accepted start
//   cin    : carry-in for add, captured on an accepted start
//   busy   : high while nibbles are being processed
//   done   : one-cycle pulse; sum/cout/ovf are valid
//   sum    : result, held until the next accepted start
//   cout   : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : signed overflow

module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_done
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic [4:0]       c;

    assign accept = start && ((state_q == st_idle) || (state_q == st_done));
    assign last   = (state_q == st_run) && (idx_q == IDXW'(NIB - 1));

    // 4-bit full-adder chain on the current nibble
    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        c[0]  = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_s[i] = nib_a[i] ^ nib_b[i] ^ c[i];
            c[i+1]   = (nib_a[i] & nib_b[i]) | (c[i] & (nib_a[i] ^ nib_b[i]));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            st_idle: if (start) state_d = st_run;
            st_run:  if (last)  state_d = st_done;
            st_done: state_d = start ? st_run : st_idle;
            default: state_d = st_idle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == st_run);
        done = (state_q == st_done);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

    // Datapath next-state
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            // Subtract is a + ~b + 1: invert b once here, force carry-in to 1
            a_d     = a;
            b_d     = b ^ {WIDTH{op_sub}};
            carry_d = op_sub ? 1'b1 : cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == st_run) begin
            sum_d[{idx_q, 2'b00} +: 4] = nib_s;
            carry_d = c[4];
            if (last) begin
                cout_d = c[4];
                ovf_d  = c[3] ^ c[4];
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
//   Directed self-checking bench for nibble_serial_add_ctrl (WIDTH = 16).
//   Inputs change 1 time unit after the rising edge; outputs are sampled there too.

module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(
        .WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_sub(op_sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and let one edge accept it
    task automatic start_op(input logic sub, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci);
        op_sub = sub;
        a      = av;
        b      = bv;
        cin    = ci;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Step until done is seen, bounded; n = edges taken
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic sub, input logic [15:0] av,
                             input logic [15:0] bv, input logic ci, input logic [15:0] esum,
                             input logic ecout, input logic eovf);
        int n;
        start_op(sub, av, bv, ci);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    endtask

    initial begin
        int n;
        int n2;

        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        // Add: wrap to zero, signed overflow, carry-in
        run_check("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        step();
        run_check("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        step();

        // Sum clears on start and fills one nibble per edge
        start_op(1'b0, 16'h1234, 16'h4321, 1'b1);
        check("clr_on_start", 32'(sum), 32'h0000);
        step();
        check("nib0_only", 32'(sum), 32'h0006);
        step();
        check("nib01", 32'(sum), 32'h0056);
        wait_done(n);
        check("cin_lat", 32'(n), 32'd2);
        check("cin_sum", 32'(sum), 32'h5556);
        check("cin_cout", 32'(cout), 32'd0);
        step();

        // Subtract; cin must be ignored
        run_check("sub_1234", 1'b1, 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0);
        step();
        run_check("sub_0_1", 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        step();
        run_check("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        step();

        // start while busy is ignored
        start_op(1'b0, 16'h0101, 16'h0202, 1'b0);
        step();
        start  = 1'b1;
        a      = 16'hFFFF;
        b      = 16'hFFFF;
        op_sub = 1'b1;
        step();
        start  = 1'b0;
        wait_done(n);
        check("ign_lat", 32'(n), 32'd2);
        check("ign_sum", 32'(sum), 32'h0303);
        check("ign_cout", 32'(cout), 32'd0);
        step();
        check("ign_done_pulse", 32'(done), 32'd0);
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("hold_sum", 32'(sum), 32'h0303);
        step();

        // Back-to-back: start held through DONE
        op_sub = 1'b0;
        cin    = 1'b0;
        a      = 16'h0001;
        b      = 16'h0002;
        start  = 1'b1;
        step();
        step();
        a = 16'h1000;
        b = 16'h2000;
        wait_done(n);
        check("b2b_lat1", 32'(n), 32'd3);
        check("b2b_sum1", 32'(sum), 32'h0003);
        step();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        wait_done(n2);
        check("b2b_gap", 32'(n2 + 1), 32'd5);
        check("b2b_sum2", 32'(sum), 32'h3000);
        step();

        // Reset mid-operation
        start_op(1'b0, 16'h1111, 16'h1111, 1'b0);
        step();
        check("pre_rst_sum", 32'(sum), 32'h0002);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        step();
        step();
        check("rst_wins_busy", 32'(busy), 32'd0);
        check("rst_wins_done", 32'(done), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        run_check("post_rst", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
